// File: rtl/adc_frame_capture.sv
// Assembles a serial ADC RX bitstream into a NUM_CH*CH_BITS frame, checks its length and publishes it
// through a valid/ready holding register. Define ADC_FC_SEQ_EN to add the frame_seq sequence output.
module adc_frame_capture #(
   parameter int CH_BITS  = 16,
   parameter int NUM_CH   = 64,
   parameter int CH_IDX_W = 6,
   parameter int SEQ_W    = 8
) (
   input  logic                        clk,
   input  logic                        rstb,
   input  logic                        start,
   input  logic                        rx_bit_valid,
   input  logic                        rx_bit,
   input  logic                        pkt_done,
   output logic [NUM_CH*CH_BITS-1:0]   dout,
   output logic                        dout_valid,
   input  logic                        dout_ready,
   input  logic [CH_IDX_W-1:0]         rd_ch,
   output logic [CH_BITS-1:0]          rd_data,
   output logic                        busy,
   output logic                        len_err,
   output logic                        overrun,
`ifdef ADC_FC_SEQ_EN
   output logic [SEQ_W-1:0]            frame_seq,
`endif
   output logic                        dbg_state
);

   localparam int FRAME_BITS = NUM_CH * CH_BITS;
   localparam int CNT_W      = $clog2(FRAME_BITS + 2);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_BITS);
   localparam logic [CNT_W-1:0] OVF_CNT  = CNT_W'(FRAME_BITS + 1);

   if (CH_IDX_W < $clog2(NUM_CH) || SEQ_W < 1) begin : g_param_check
      $error("adc_frame_capture: CH_IDX_W too narrow for NUM_CH or SEQ_W < 1");
   end

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RECV = 1'b1
   } state_t;

   // Handshake: dout is offered while dout_valid=1 and is consumed on any clock edge where
   // dout_valid=1 and dout_ready=1; dout never changes while dout_valid=1 except by a
   // publish on that same accepting edge.
   state_t                  state_q, state_d;
   logic [FRAME_BITS-1:0]   shift_q, shift_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [FRAME_BITS-1:0]   dout_q, dout_d;
   logic                    valid_q, valid_d;
   logic                    len_err_q, len_err_d;
   logic                    overrun_q, overrun_d;

   logic [FRAME_BITS-1:0]   shift_rx;
   logic [CNT_W-1:0]        cnt_rx;
   logic                    good;
   logic                    publish;

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      cnt_d     = cnt_q;
      dout_d    = dout_q;
      valid_d   = valid_q;
      len_err_d = 1'b0;
      overrun_d = 1'b0;
      good      = 1'b0;
      publish   = 1'b0;
      shift_rx  = shift_q;
      cnt_rx    = cnt_q;

      // A bit arriving with pkt_done is counted before the frame is judged.
      if (rx_bit_valid) begin
         if (cnt_q < FULL_CNT) begin
            shift_rx = {shift_q[FRAME_BITS-2:0], rx_bit};
            cnt_rx   = cnt_q + 1'b1;
         end else begin
            cnt_rx   = OVF_CNT;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               shift_d = '0;
               cnt_d   = '0;
               state_d = S_RECV;
            end
         end
         S_RECV: begin
            shift_d = shift_rx;
            cnt_d   = cnt_rx;
            if (start) begin
               shift_d = '0;
               cnt_d   = '0;
            end else if (pkt_done) begin
               state_d = S_IDLE;
               if (cnt_rx == FULL_CNT) begin
                  good = 1'b1;
                  if (!valid_q || dout_ready) begin
                     publish = 1'b1;
                  end else begin
                     overrun_d = 1'b1;
                  end
               end else begin
                  len_err_d = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (publish) begin
         dout_d  = shift_rx;
         valid_d = 1'b1;
      end else if (valid_q && dout_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstb) begin
         state_q   <= S_IDLE;
         shift_q   <= '0;
         cnt_q     <= '0;
         dout_q    <= '0;
         valid_q   <= 1'b0;
         len_err_q <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         cnt_q     <= cnt_d;
         dout_q    <= dout_d;
         valid_q   <= valid_d;
         len_err_q <= len_err_d;
         overrun_q <= overrun_d;
      end
   end

`ifdef ADC_FC_SEQ_EN
   logic [SEQ_W-1:0] seq_q, seq_d;
   logic [SEQ_W-1:0] fseq_q, fseq_d;

   // Counts every good frame, dropped or not, so skipped numbers expose overruns.
   always_comb begin
      seq_d  = seq_q;
      fseq_d = fseq_q;
      if (good) begin
         seq_d = seq_q + 1'b1;
      end
      if (publish) begin
         fseq_d = seq_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstb) begin
         seq_q  <= '0;
         fseq_q <= '0;
      end else begin
         seq_q  <= seq_d;
         fseq_q <= fseq_d;
      end
   end

   assign frame_seq = fseq_q;
`endif

   // Channel 0 occupies the most significant word of the frame.
   always_comb begin
      rd_data = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (32'(rd_ch) == i) begin
            rd_data = dout_q[FRAME_BITS-1-i*CH_BITS -: CH_BITS];
         end
      end
   end

   assign dout       = dout_q;
   assign dout_valid = valid_q;
   assign busy       = (state_q == S_RECV);
   assign len_err    = len_err_q;
   assign overrun    = overrun_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_adc_frame_capture.sv
// Bench for adc_frame_capture at CH_BITS=8, NUM_CH=4 (32-bit frames), SEQ_W=2; frame_seq
// is exercised when ADC_FC_SEQ_EN is defined for both bench and design.
module tb_adc_frame_capture;

   localparam int FB = 32;

   logic          clk;
   logic          rstb;
   logic          start;
   logic          rx_bit_valid;
   logic          rx_bit;
   logic          pkt_done;
   logic [FB-1:0] dout;
   logic          dout_valid;
   logic          dout_ready;
   logic [2:0]    rd_ch;
   logic [7:0]    rd_data;
   logic          busy;
   logic          len_err;
   logic          overrun;
   logic          dbg_state;
`ifdef ADC_FC_SEQ_EN
   logic [1:0]    frame_seq;
`endif

   adc_frame_capture #(
      .CH_BITS  (8),
      .NUM_CH   (4),
      .CH_IDX_W (3),
      .SEQ_W    (2)
   ) dut (
      .clk          (clk),
      .rstb         (rstb),
      .start        (start),
      .rx_bit_valid (rx_bit_valid),
      .rx_bit       (rx_bit),
      .pkt_done     (pkt_done),
      .dout         (dout),
      .dout_valid   (dout_valid),
      .dout_ready   (dout_ready),
      .rd_ch        (rd_ch),
      .rd_data      (rd_data),
      .busy         (busy),
      .len_err      (len_err),
      .overrun      (overrun),
`ifdef ADC_FC_SEQ_EN
      .frame_seq    (frame_seq),
`endif
      .dbg_state    (dbg_state)
   );

   // clock/reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // reference model: the frame is a list of received bits, judged at pkt_done
   bit            fq[$];
   bit            m_ovf;
   bit            m_busy;
   logic [FB-1:0] m_dout;
   bit            m_valid;
   bit            m_len_err;
   bit            m_overrun;
   int            m_seq_ctr;
   logic [1:0]    m_fseq;
   logic [FB-1:0] exp_q[$];

   typedef struct packed {
      logic s;
      logic bv;
      logic b;
      logic pd;
   } stim_t;

   task automatic model_reset();
      fq.delete();
      exp_q.delete();
      m_ovf = 0; m_busy = 0; m_dout = '0; m_valid = 0;
      m_len_err = 0; m_overrun = 0; m_seq_ctr = 0; m_fseq = '0;
   endtask

   task automatic model_step(input logic s, input logic bv, input logic b, input logic pd,
                             input logic rdy);
      logic          pub;
      logic          was_valid;
      logic [FB-1:0] val;
      pub = 0;
      was_valid = m_valid;
      m_len_err = 0;
      m_overrun = 0;
      if (!m_busy) begin
         if (s) begin
            fq.delete(); m_ovf = 0; m_busy = 1;
         end
      end else begin
         if (bv) begin
            if (fq.size() < FB) fq.push_back(b);
            else m_ovf = 1;
         end
         if (s) begin
            fq.delete(); m_ovf = 0;
         end else if (pd) begin
            m_busy = 0;
            if (!m_ovf && fq.size() == FB) begin
               val = '0;
               foreach (fq[i]) val = {val[FB-2:0], fq[i]};
               if (!was_valid || rdy) begin
                  pub = 1; m_dout = val; m_fseq = 2'(m_seq_ctr);
               end else begin
                  m_overrun = 1;
               end
               m_seq_ctr = (m_seq_ctr + 1) % 4;
            end else begin
               m_len_err = 1;
            end
         end
      end
      if (was_valid && rdy) void'(exp_q.pop_front());
      if (pub) exp_q.push_back(m_dout);
      m_valid = pub ? 1'b1 : ((was_valid && rdy) ? 1'b0 : was_valid);
   endtask

   // driver tasks: inputs applied 1 time unit after an edge, outputs seen 1 unit after the next
   task automatic cycle(input logic s, input logic bv, input logic b, input logic pd,
                        input logic rdy);
      start = s; rx_bit_valid = bv; rx_bit = b; pkt_done = pd; dout_ready = rdy;
      if (!rstb) model_reset();
      else model_step(s, bv, b, pd, rdy);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rstb = 1'b0;
      cycle(0, 1, 1, 1, 1);
      cycle(1, 1, 0, 0, 0);
      rstb = 1'b1;
   endtask

   // start, n bits MSB-first (beyond 32 random), pkt_done with or after the last bit;
   // dout_ready is driven only on the pkt_done cycle
   task automatic send_bits(input logic [31:0] v, input int n, input logic pd_last,
                            input logic rdy_pd);
      logic b;
      cycle(1, 0, 0, 0, 0);
      for (int i = 0; i < n; i++) begin
         b = (i < 32) ? v[31-i] : 1'($urandom_range(0, 1));
         if (pd_last && i == n - 1) cycle(0, 1, b, 1, rdy_pd);
         else cycle(0, 1, b, 0, 0);
      end
      if (!pd_last) cycle(0, 0, 0, 1, rdy_pd);
   endtask

   task automatic test_reset();
      do_reset();
      n_chk++; if (dout !== 32'h0) $display("FAIL rst_dout got %h exp 0", dout); else n_pass++;
      n_chk++; if (dout_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", dout_valid); else n_pass++;
      n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy); else n_pass++;
      n_chk++; if ({len_err, overrun} !== 2'b00) $display("FAIL rst_pulses got %b exp 00", {len_err, overrun}); else n_pass++;
      send_bits(32'hDEADBEEF, 32, 0, 0);
      cycle(1, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) cycle(0, 1, 1'(i), 0, 0);
      do_reset();
      n_chk++; if ({dout_valid, busy, len_err, overrun} !== 4'b0000) $display("FAIL midrst_flags got %b exp 0000", {dout_valid, busy, len_err, overrun}); else n_pass++;
      n_chk++; if (dout !== 32'h0) $display("FAIL midrst_dout got %h exp 0", dout); else n_pass++;
      send_bits(32'h12345678, 32, 0, 0);
      n_chk++; if (dout !== 32'h12345678) $display("FAIL postrst_dout got %h exp 12345678", dout); else n_pass++;
      n_chk++; if (dout_valid !== 1'b1) $display("FAIL postrst_valid got %b exp 1", dout_valid); else n_pass++;
   endtask

   task automatic test_capture();
      cycle(0, 0, 0, 0, 1);
      n_chk++; if (dout_valid !== 1'b0) $display("FAIL consume_valid got %b exp 0", dout_valid); else n_pass++;
      send_bits(32'hA1B2C3D4, 32, 0, 0);
      n_chk++; if (dout !== 32'hA1B2C3D4) $display("FAIL cap_dout got %h exp a1b2c3d4", dout); else n_pass++;
      n_chk++; if (dout_valid !== 1'b1) $display("FAIL cap_valid got %b exp 1", dout_valid); else n_pass++;
      n_chk++; if ({busy, len_err, overrun} !== 3'b000) $display("FAIL cap_flags got %b exp 000", {busy, len_err, overrun}); else n_pass++;
      rd_ch = 3'd0; #1;
      n_chk++; if (rd_data !== 8'hA1) $display("FAIL rd_ch0 got %h exp a1", rd_data); else n_pass++;
      rd_ch = 3'd3; #1;
      n_chk++; if (rd_data !== 8'hD4) $display("FAIL rd_ch3 got %h exp d4", rd_data); else n_pass++;
      rd_ch = 3'd5; #1;
      n_chk++; if (rd_data !== 8'h00) $display("FAIL rd_ch5 got %h exp 00", rd_data); else n_pass++;
      cycle(0, 0, 0, 0, 0);
      n_chk++; if (dout_valid !== 1'b1 || dout !== 32'hA1B2C3D4) $display("FAIL cap_hold got %b/%h exp 1/a1b2c3d4", dout_valid, dout); else n_pass++;
   endtask

   task automatic test_len_err();
      send_bits(32'h55AA55AA, 31, 0, 0);
      n_chk++; if (len_err !== 1'b1) $display("FAIL short_len_err got %b exp 1", len_err); else n_pass++;
      n_chk++; if (dout !== 32'hA1B2C3D4 || dout_valid !== 1'b1) $display("FAIL short_dout got %h/%b exp a1b2c3d4/1", dout, dout_valid); else n_pass++;
      cycle(0, 0, 0, 0, 0);
      n_chk++; if (len_err !== 1'b0) $display("FAIL short_pulse_len got %b exp 0", len_err); else n_pass++;
      send_bits(32'h0F0F0F0F, 33, 1, 0);
      n_chk++; if (len_err !== 1'b1) $display("FAIL long_len_err got %b exp 1", len_err); else n_pass++;
      n_chk++; if (dout !== 32'hA1B2C3D4) $display("FAIL long_dout got %h exp a1b2c3d4", dout); else n_pass++;
   endtask

   task automatic test_overrun();
      cycle(0, 0, 0, 0, 1);
      send_bits(32'h11223344, 32, 0, 0);
      send_bits(32'h55667788, 32, 1, 0);
      n_chk++; if (overrun !== 1'b1) $display("FAIL ovr_pulse got %b exp 1", overrun); else n_pass++;
      n_chk++; if (dout !== 32'h11223344 || dout_valid !== 1'b1) $display("FAIL ovr_dout got %h/%b exp 11223344/1", dout, dout_valid); else n_pass++;
      n_chk++; if (len_err !== 1'b0) $display("FAIL ovr_len_err got %b exp 0", len_err); else n_pass++;
      cycle(0, 0, 0, 0, 0);
      n_chk++; if (overrun !== 1'b0) $display("FAIL ovr_pulse_end got %b exp 0", overrun); else n_pass++;
      send_bits(32'h99AABBCC, 32, 0, 1);
      n_chk++; if (dout !== 32'h99AABBCC || dout_valid !== 1'b1) $display("FAIL b2b_dout got %h/%b exp 99aabbcc/1", dout, dout_valid); else n_pass++;
      n_chk++; if (overrun !== 1'b0) $display("FAIL b2b_overrun got %b exp 0", overrun); else n_pass++;
   endtask

   task automatic test_start_pkt_done();
      cycle(0, 0, 0, 0, 1);
      cycle(1, 0, 0, 0, 0);
      for (int i = 0; i < 32; i++) cycle(0, 1, 1'($urandom_range(0, 1)), 0, 0);
      cycle(1, 0, 0, 1, 0);
      n_chk++; if ({dout_valid, len_err, overrun} !== 3'b000) $display("FAIL spd_flags got %b exp 000", {dout_valid, len_err, overrun}); else n_pass++;
      n_chk++; if (busy !== 1'b1) $display("FAIL spd_busy got %b exp 1", busy); else n_pass++;
      cycle(0, 0, 0, 1, 0);
      n_chk++; if (len_err !== 1'(m_len_err) || busy !== 1'b0) $display("FAIL spd_empty got %b/%b exp %b/0", len_err, busy, m_len_err); else n_pass++;
   endtask

`ifdef ADC_FC_SEQ_EN
   task automatic test_seq();
      int seq_exp[5] = '{0, 1, 2, 3, 0};
      do_reset();
      send_bits(32'h01010101, 32, 0, 0);
      n_chk++; if (frame_seq !== 2'd0) $display("FAIL seq_first got %0d exp 0", frame_seq); else n_pass++;
      send_bits(32'h02020202, 32, 0, 0);
      n_chk++; if (overrun !== 1'b1 || frame_seq !== 2'd0) $display("FAIL seq_ovr got %b/%0d exp 1/0", overrun, frame_seq); else n_pass++;
      cycle(0, 0, 0, 0, 1);
      send_bits(32'h03030303, 32, 0, 0);
      n_chk++; if (frame_seq !== 2'd2 || dout !== 32'h03030303) $display("FAIL seq_gap got %0d/%h exp 2/03030303", frame_seq, dout); else n_pass++;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         cycle(0, 0, 0, 0, 1);
         send_bits($urandom, 32, 0, 0);
         n_chk++; if (frame_seq !== 2'(seq_exp[i])) $display("FAIL seq_wrap%0d got %0d exp %0d", i, frame_seq, seq_exp[i]); else n_pass++;
      end
   endtask
`endif

   task automatic test_random();
      stim_t       sq[$];
      stim_t       t;
      int          lens[6] = '{32, 32, 32, 31, 33, 34};
      logic [31:0] v;
      int          n;
      int          c;
      logic        rdy;
      logic [7:0]  exp_rd;
      do_reset();
      for (int f = 0; f < 40; f++) begin
         sq.delete();
         v = $urandom;
         n = lens[$urandom_range(0, 5)];
         if ($urandom_range(0, 5) == 0) sq.push_back('{s: 0, bv: 1, b: 1, pd: 1});
         sq.push_back('{s: 1, bv: 0, b: 0, pd: 0});
         for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) sq.push_back('{s: 0, bv: 0, b: 0, pd: 0});
            sq.push_back('{s: 0, bv: 1, b: ((i < 32) ? v[31-i] : 1'($urandom_range(0, 1))), pd: 0});
         end
         case ($urandom_range(0, 5))
            0: begin t = sq.pop_back(); t.pd = 1'b1; sq.push_back(t); end
            1: sq.push_back('{s: 1, bv: 0, b: 0, pd: 1});
            default: sq.push_back('{s: 0, bv: 0, b: 0, pd: 1});
         endcase
         sq.push_back('{s: 0, bv: 0, b: 0, pd: 0});
         foreach (sq[k]) begin
            rdy = ($urandom_range(0, 2) == 0);
            rd_ch = 3'($urandom_range(0, 7));
            if (rdy && m_valid && exp_q.size() > 0) begin
               n_chk++; if (dout !== exp_q[0]) $display("FAIL rnd_accept f%0d got %h exp %h", f, dout, exp_q[0]); else n_pass++;
            end
            cycle(sq[k].s, sq[k].bv, sq[k].b, sq[k].pd, rdy);
            c = int'(rd_ch);
            exp_rd = (c < 4) ? 8'(m_dout >> ((3 - c) * 8)) : 8'h00;
            n_chk++; if (dout !== m_dout) $display("FAIL rnd_dout f%0d got %h exp %h", f, dout, m_dout); else n_pass++;
            n_chk++; if ({dout_valid, busy, len_err, overrun} !== {1'(m_valid), 1'(m_busy), 1'(m_len_err), 1'(m_overrun)})
               $display("FAIL rnd_flags f%0d got %b exp %b", f, {dout_valid, busy, len_err, overrun}, {m_valid, m_busy, m_len_err, m_overrun});
            else n_pass++;
            n_chk++; if (rd_data !== exp_rd) $display("FAIL rnd_rd f%0d ch%0d got %h exp %h", f, c, rd_data, exp_rd); else n_pass++;
`ifdef ADC_FC_SEQ_EN
            n_chk++; if (frame_seq !== m_fseq) $display("FAIL rnd_seq f%0d got %0d exp %0d", f, frame_seq, m_fseq); else n_pass++;
`endif
         end
      end
   endtask

   initial begin
      rstb = 1'b0;
      start = 1'b0; rx_bit_valid = 1'b0; rx_bit = 1'b0; pkt_done = 1'b0;
      dout_ready = 1'b0; rd_ch = '0;
      model_reset();
      test_reset();
      test_capture();
      test_len_err();
      test_overrun();
      test_start_pkt_done();
`ifdef ADC_FC_SEQ_EN
      test_seq();
`endif
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
